// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
//
// Owns the PC and issues instruction-memory requests over a ready handshake.
// It applies hazard-unit stalls, flushes and branch/jump redirects.
// A bubble in IF/ID is Instruction=0, PCPlus4=0, IFID_Valid=0.
//
// Parameters:
//   RESET_PC     PC loaded on reset
// Ports:
//   Clk, Rst     clock; synchronous active-high reset
//   Stall        hold IF/ID and PC
//   Flush        load a bubble into IF/ID (PC, FSM and skid unaffected)
//   Redirect     taken branch / jump resolved in ID, target on RedirectPC
//   imem_req     fetch request (forced low while Rst=1)
//   imem_addr    fetch address (current PC)
//   imem_rdata   instruction word, valid with imem_ready
//   imem_ready   response strobe, may assert in the request cycle
//   Instruction  IF/ID instruction word
//   PCPlus4      IF/ID PC+4
//   IFID_Valid   IF/ID holds a real instruction
//
// Build option:
//   FETCH_DELAY_SLOT_EN  when defined, the word after a branch is kept as a
//                        delay slot; otherwise that word is squashed.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        IFID_Valid
);

    typedef enum logic [1:0] {FETCH, HELD, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        redir;
    logic [31:0] pc_plus4;
`ifdef FETCH_DELAY_SLOT_EN
    logic        pend_q, pend_d;
    logic [31:0] next_pc;
`endif

    assign imem_req    = !Rst && (state_q != HELD);
    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign PCPlus4     = pc4_q;
    assign IFID_Valid  = valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        tgt_d        = tgt_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        // Redirect is only honoured when not stalled; the hazard unit holds it.
        redir        = Redirect && !Stall;
        pc_plus4     = pc_q + 32'd4;
`ifdef FETCH_DELAY_SLOT_EN
        pend_d       = pend_q;
        // The target replaces +4 when the delay-slot word is accepted.
        if (redir)       next_pc = RedirectPC;
        else if (pend_q) next_pc = tgt_q;
        else             next_pc = pc_plus4;

        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    pc_d   = next_pc;
                    pend_d = 1'b0;
                    if (Stall) begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus4;
                        state_d      = HELD;
                    end else begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                    end
                end else begin
                    if (redir) begin
                        pend_d = 1'b1;
                        tgt_d  = RedirectPC;
                    end
                    if (!Stall) begin
                        instr_d = '0;
                        pc4_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            HELD: begin
                if (!Stall) begin
                    instr_d = skid_instr_q;
                    pc4_d   = skid_pc4_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                    // pc_q already moved past the skid word (the delay slot).
                    if (redir) pc_d = RedirectPC;
                end
            end
            default: state_d = FETCH;
        endcase
`else
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (redir) begin
                        pc_d    = RedirectPC;
                        instr_d = '0;
                        pc4_d   = '0;
                        valid_d = 1'b0;
                    end else if (Stall) begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_plus4;
                        pc_d         = pc_plus4;
                        state_d      = HELD;
                    end else begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end else if (redir) begin
                    // Outstanding request must complete before the PC may move.
                    tgt_d   = RedirectPC;
                    state_d = DRAIN;
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end
            HELD: begin
                if (redir) begin
                    pc_d    = RedirectPC;
                    state_d = FETCH;
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    instr_d = skid_instr_q;
                    pc4_d   = skid_pc4_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redir) tgt_d = RedirectPC;
                if (!Stall) begin
                    instr_d = '0;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
                if (imem_ready) begin
                    pc_d    = redir ? RedirectPC : tgt_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
`endif
        // Flush overrides Stall for IF/ID only.
        if (Flush) begin
            instr_d = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
            tgt_q        <= '0;
            instr_q      <= '0;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
            pend_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            tgt_q        <= tgt_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
`ifdef FETCH_DELAY_SLOT_EN
            pend_q       <= pend_d;
`endif
        end
    end

endmodule
